// File: rtl/rgmii_tx_sdr_serializer.sv
// RGMII transmit output stage, single-data-rate at 250 MHz.
// One GMII byte is taken per byte period (strobe gmii_tx_ready) and driven
// out as two nibbles with a generated TX clock. 10/100/1000 rates are made
// by stretching the byte period with a phase counter.
// Optional build macro RGMII_TX_STATS_EN adds frame/byte/error counters.
module rgmii_tx_sdr_serializer #(
  parameter int          CNT_W    = 8,
  parameter logic [3:0]  IDLE_TXD = 4'h0
) (
  input  logic        gtx_clk250,
  input  logic        tx_rst,
  input  logic [1:0]  speed,
  input  logic [7:0]  gmii_txd,
  input  logic        gmii_tx_en,
  input  logic        gmii_tx_er,
  output logic        gmii_tx_ready,
  output logic        rgmii_tx_clk,
  output logic [3:0]  rgmii_txd,
  output logic        rgmii_tx_ctl
`ifdef RGMII_TX_STATS_EN
  ,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_bytes,
  output logic [15:0] stat_err_bytes
`endif
);

  localparam logic [1:0] SPD_10M  = 2'b00;
  localparam logic [1:0] SPD_100M = 2'b01;
  localparam logic [1:0] SPD_1G   = 2'b10;

  localparam logic [CNT_W-1:0] T_1G    = CNT_W'(1);
  localparam logic [CNT_W-1:0] T_100M  = CNT_W'(19);
  localparam logic [CNT_W-1:0] T_10M   = CNT_W'(199);
  localparam logic [CNT_W-1:0] H_100M  = CNT_W'(10);
  localparam logic [CNT_W-1:0] H_10M   = CNT_W'(100);
  localparam logic [CNT_W-1:0] CH_100M = CNT_W'(5);
  localparam logic [CNT_W-1:0] CH_10M  = CNT_W'(50);

  logic [CNT_W-1:0] cnt, cnt_next, term, pos;
  logic [1:0]       speed_r, spd_next;
  logic [7:0]       txd_r, txd_next;
  logic             en_r, er_r, en_next, er_next;
  logic             ready, half, clk_hi;
  logic [3:0]       nib;

  // Terminal count of the byte period for the latched speed
  always_comb begin
    case (speed_r)
      SPD_10M:  term = T_10M;
      SPD_100M: term = T_100M;
      default:  term = T_1G;
    endcase
  end

  assign ready         = (cnt == term);
  assign gmii_tx_ready = ready & ~tx_rst;

  // Values the state registers take at the next edge; outputs are built
  // from these so the pins line up with the counter phase.
  always_comb begin
    cnt_next = ready ? '0 : cnt + CNT_W'(1);
    spd_next = ready ? speed : speed_r;
    txd_next = ready ? gmii_txd : txd_r;
    en_next  = ready ? gmii_tx_en : en_r;
    er_next  = ready ? gmii_tx_er : er_r;
  end

  // Nibble half and clock-high window from the next phase
  always_comb begin
    half   = 1'b0;
    pos    = cnt_next;
    clk_hi = 1'b0;
    case (spd_next)
      SPD_10M: begin
        half   = (cnt_next >= H_10M);
        pos    = half ? cnt_next - H_10M : cnt_next;
        clk_hi = (pos < CH_10M);
      end
      SPD_100M: begin
        half   = (cnt_next >= H_100M);
        pos    = half ? cnt_next - H_100M : cnt_next;
        clk_hi = (pos < CH_100M);
      end
      default: begin
        half   = cnt_next[0];
        clk_hi = ~cnt_next[0];
      end
    endcase
    nib = half ? txd_next[7:4] : txd_next[3:0];
  end

  // Phase counter, latched speed and byte register
  always_ff @(posedge gtx_clk250 or posedge tx_rst) begin
    if (tx_rst) begin
      cnt     <= T_1G;
      speed_r <= SPD_1G;
      txd_r   <= '0;
      en_r    <= 1'b0;
      er_r    <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      speed_r <= spd_next;
      txd_r   <= txd_next;
      en_r    <= en_next;
      er_r    <= er_next;
    end
  end

  // Registered pin drivers
  always_ff @(posedge gtx_clk250 or posedge tx_rst) begin
    if (tx_rst) begin
      rgmii_tx_clk <= 1'b0;
      rgmii_txd    <= IDLE_TXD;
      rgmii_tx_ctl <= 1'b0;
    end else begin
      rgmii_tx_clk <= clk_hi;
      rgmii_txd    <= (en_next | er_next) ? nib : IDLE_TXD;
      rgmii_tx_ctl <= clk_hi ? en_next : (en_next ^ er_next);
    end
  end

`ifdef RGMII_TX_STATS_EN
  // Counters advance on captured bytes; en_r still holds the previous byte
  always_ff @(posedge gtx_clk250 or posedge tx_rst) begin
    if (tx_rst) begin
      stat_frames    <= '0;
      stat_bytes     <= '0;
      stat_err_bytes <= '0;
    end else if (ready) begin
      if (gmii_tx_en)               stat_bytes     <= stat_bytes + 32'd1;
      if (gmii_tx_en && gmii_tx_er) stat_err_bytes <= stat_err_bytes + 16'd1;
      if (!gmii_tx_en && en_r)      stat_frames    <= stat_frames + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
